fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  - Sequences a radix-2 in-place FFT over SAMPLES points.
//  - Walks every stage and emits one butterfly index pair (idx_a, idx_b) plus a twiddle index per transfer.
//  - Feeds the shared butterfly/memory datapath that follows the bit-reversal reorder stage.
//  - One pair is issued per valid/ready handshake; a single start runs all log2(SAMPLES) stages.
// PARAMETERS
//  - SAMPLES  8  FFT length; power of two, >= 4.
//  - LOG2N    $clog2(SAMPLES)  Derived; number of stages and index width. Not to be overridden.
// PORTS
//  - clk          in   1              Clock; all state updates on the rising edge.
//  - rst_n        in   1              Asynchronous active-low reset.
//  - start        in   1              Pulse; starts a transform when idle.
//  - busy         out  1              High from the cycle after start is accepted until done.
//  - done         out  1              One-cycle pulse once all stages have been issued (and flushed, see CONFIGURATION).
//  - bf_valid     out  1              A butterfly pair is presented.
//  - bf_ready     in   1              Butterfly unit accepts the pair. Transfer = bf_valid & bf_ready.
//  - idx_a        out  LOG2N          Upper-leg sample index.
//  - idx_b        out  LOG2N          Lower-leg sample index; always idx_a + (1<<stage).
//  - twiddle_idx  out  LOG2N-1        Twiddle ROM address W_N^k.
//  - stage        out  $clog2(LOG2N)  Current stage, 0..LOG2N-1.
//  - bf_flushed   in   1              Butterfly pipeline empty. Used only with FFT_STAGE_BARRIER_EN.
// BEHAVIOUR
//  - Reset (asynchronous, rst_n=0):
//    - State IDLE; pair counter p=0; stage=0.
//    - busy=0, done=0, bf_valid=0, idx_a=0, idx_b=0, twiddle_idx=0.
//  - FSM states IDLE, RUN, FLUSH, FIN.
//  - IDLE -> RUN when start=1. start is ignored in every other state.
//    - Next cycle: busy=1, bf_valid=1, stage=0, p=0.
//  - RUN: the outputs are registered decodes of (stage s, p), with p in 0..SAMPLES/2-1:
//    - idx_a = ((p >> s) << (s+1)) | (p & ((1<<s)-1))
//    - idx_b = idx_a | (1<<s)
//    - twiddle_idx = (p & ((1<<s)-1)) << (LOG2N-1-s)
//    - All arithmetic is unsigned and truncated to the port widths.
//  - While bf_valid=1 and bf_ready=0, idx_a, idx_b, twiddle_idx and stage hold stable.
//  - On a transfer with p < SAMPLES/2-1: p increments; the next pair is presented the following cycle with no bubble.
//  - On a transfer with p = SAMPLES/2-1 (end of stage): p wraps to 0.
//    - If s < LOG2N-1: stage increments (via FLUSH when the macro is defined).
//    - If s = LOG2N-1: go to FIN; bf_valid=0 from the next cycle.
//  - FIN (one cycle): done=1, busy=0, then return to IDLE.
//    - done rises on the cycle after the final transfer (FLUSH rules permitting).
//  - A start pulse in the same cycle as done is ignored; start must be re-asserted in IDLE.
//  - Total transfers per transform: (SAMPLES/2)*LOG2N. With bf_ready held at 1, done asserts exactly that many cycles after busy rises.
//  - bf_ready while bf_valid=0 has no effect.
//  - Reset mid-transform aborts immediately to the reset values. No done is produced.
// CONFIGURATION
//  - FFT_STAGE_BARRIER_EN defined:
//    - After the last transfer of each stage (including the final one), enter FLUSH with bf_valid=0.
//    - Remain in FLUSH until bf_flushed=1, then advance the stage and return to RUN, or go to FIN after the last stage.
//    - Guarantees no read-after-write hazard across stages.
//  - FFT_STAGE_BARRIER_EN undefined:
//    - No FLUSH state; stages run back-to-back and bf_flushed is ignored.
// TESTING
//  - SAMPLES=8, bf_ready=1, start pulse -> 12 transfers:
//    - Stage 0: (0,1)(2,3)(4,5)(6,7), all tw 0.
//    - Stage 1: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
//    - Stage 2: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
//    - done is a single pulse 12 cycles after busy rises.
//  - bf_ready toggling 1,0,0,1... -> outputs stable while stalled; the same 12-pair sequence; no pair duplicated or skipped.
//  - start pulsed again mid-transform -> ignored; sequence and done timing unchanged.
//  - rst_n low at transfer 5 -> all outputs 0 asynchronously, no done; a new start replays from (0,1).
//  - SAMPLES=16 -> 32 transfers; stage 3 pair p=5 is (5,13) with tw 5.
//  - With FFT_STAGE_BARRIER_EN and bf_flushed held at 0 for 3 cycles after each stage:
//    - bf_valid=0 for those 3 cycles, then the next stage resumes.
//    - done follows the final flush.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Issues the butterfly index pairs and twiddle addresses for an
//               in-place radix-2 FFT of SAMPLES points. One start runs all
//               LOG2N stages and issues one pair per valid/ready transfer.
//               Optional macro FFT_STAGE_BARRIER_EN inserts a FLUSH state
//               after each stage and waits for bf_flushed before moving on.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
  parameter int SAMPLES = 8,
  localparam int LOG2N = $clog2(SAMPLES),
  localparam int SW = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] idx_a,
  output logic [LOG2N-1:0] idx_b,
  output logic [LOG2N-2:0] twiddle_idx,
  output logic [SW-1:0]    stage,
  input  logic             bf_flushed
);

  localparam logic [LOG2N-2:0] C_P_LAST = (LOG2N-1)'(SAMPLES/2 - 1);
  localparam logic [SW-1:0]    C_S_LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           r_state;
  logic [LOG2N-2:0] r_p;

  // Upper-leg index: insert a zero bit at position s into the pair counter.
  function automatic logic [LOG2N-1:0] f_idx_a(input logic [SW-1:0] s,
                                               input logic [LOG2N-2:0] p);
    logic [LOG2N-1:0] w_p;
    logic [LOG2N-1:0] w_mask;
    w_p    = {1'b0, p};
    w_mask = (LOG2N'(1) << s) - LOG2N'(1);
    return (((w_p >> s) << 1) << s) | (w_p & w_mask);
  endfunction

  // Lower leg sits exactly one span (1<<s) above the upper leg.
  function automatic logic [LOG2N-1:0] f_idx_b(input logic [SW-1:0] s,
                                               input logic [LOG2N-2:0] p);
    return f_idx_a(s, p) | (LOG2N'(1) << s);
  endfunction

  // Twiddle exponent: position within the butterfly group scaled to N/2 range.
  function automatic logic [LOG2N-2:0] f_tw(input logic [SW-1:0] s,
                                            input logic [LOG2N-2:0] p);
    logic [LOG2N-2:0] w_mask;
    logic [SW:0]      w_sh;
    // For s = LOG2N-1 the shift wraps to zero and the mask becomes all ones.
    w_mask = ((LOG2N-1)'(1) << s) - (LOG2N-1)'(1);
    w_sh   = (SW+1)'(LOG2N - 1) - {1'b0, s};
    return (p & w_mask) << w_sh;
  endfunction

`ifndef FFT_STAGE_BARRIER_EN
  // The flush handshake only matters with the stage barrier built in.
  logic w_unused_flushed;
  assign w_unused_flushed = bf_flushed;
`endif

  // Sequencer FSM; every output is a registered decode of (stage, p).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      stage       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bf_valid    <= 1'b0;
      idx_a       <= '0;
      idx_b       <= '0;
      twiddle_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            busy        <= 1'b1;
            bf_valid    <= 1'b1;
            stage       <= '0;
            r_p         <= '0;
            idx_a       <= f_idx_a('0, '0);
            idx_b       <= f_idx_b('0, '0);
            twiddle_idx <= f_tw('0, '0);
          end
        end
        S_RUN: begin
          // bf_valid is always high here, so bf_ready alone marks a transfer.
          if (bf_ready) begin
            if (r_p != C_P_LAST) begin
              r_p         <= r_p + 1'b1;
              idx_a       <= f_idx_a(stage, r_p + 1'b1);
              idx_b       <= f_idx_b(stage, r_p + 1'b1);
              twiddle_idx <= f_tw(stage, r_p + 1'b1);
            end else begin
              r_p <= '0;
`ifdef FFT_STAGE_BARRIER_EN
              r_state  <= S_FLUSH;
              bf_valid <= 1'b0;
`else
              if (stage != C_S_LAST) begin
                stage       <= stage + 1'b1;
                idx_a       <= f_idx_a(stage + 1'b1, '0);
                idx_b       <= f_idx_b(stage + 1'b1, '0);
                twiddle_idx <= f_tw(stage + 1'b1, '0);
              end else begin
                r_state  <= S_FIN;
                bf_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
`endif
            end
          end
        end
`ifdef FFT_STAGE_BARRIER_EN
        S_FLUSH: begin
          if (bf_flushed) begin
            if (stage != C_S_LAST) begin
              r_state     <= S_RUN;
              bf_valid    <= 1'b1;
              stage       <= stage + 1'b1;
              idx_a       <= f_idx_a(stage + 1'b1, '0);
              idx_b       <= f_idx_b(stage + 1'b1, '0);
              twiddle_idx <= f_tw(stage + 1'b1, '0);
            end else begin
              r_state <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
`endif
        S_FIN: begin
          // start is deliberately not sampled here.
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          bf_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_sequencer
// Description : Directed bench for fft_stage_sequencer (SAMPLES=8 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

`ifdef FFT_STAGE_BARRIER_EN
  localparam int EXTRA8  = 3;
  localparam int EXTRA16 = 4;
`else
  localparam int EXTRA8  = 0;
  localparam int EXTRA16 = 0;
`endif
  localparam int EXP_DONE8  = 12 + EXTRA8;
  localparam int EXP_DONE16 = 32 + EXTRA16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       bf_ready = 1'b0;
  logic       bf_flushed = 1'b1;
  logic       busy, done, bf_valid;
  logic [2:0] idx_a, idx_b;
  logic [1:0] twiddle_idx, stage;

  logic       start16 = 1'b0;
  logic       ready16 = 1'b0;
  logic       busy16, done16, valid16;
  logic [3:0] a16, b16;
  logic [2:0] tw16;
  logic [1:0] st16;

  int total = 0;
  int bad = 0;

  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int got_a[64], got_b[64], got_tw[64], got_st[64];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.SAMPLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .idx_a(idx_a), .idx_b(idx_b),
    .twiddle_idx(twiddle_idx), .stage(stage), .bf_flushed(bf_flushed)
  );

  fft_stage_sequencer #(.SAMPLES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
    .bf_valid(valid16), .bf_ready(ready16), .idx_a(a16), .idx_b(b16),
    .twiddle_idx(tw16), .stage(st16), .bf_flushed(bf_flushed)
  );

  // Runs one SAMPLES=8 transform from a negedge in IDLE and records transfers.
  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic run8(input int mode, input bit poke, output int ntx,
                      output int t_done, output int ndone, output int nunstable,
                      output bit busy0, output bit busy_after);
    bit stalled = 1'b0;
    int pa = 0, pb = 0, pt = 0, ps = 0;
    ntx = 0; t_done = -1; ndone = 0; nunstable = 0; busy0 = 1'b0; busy_after = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        ndone++;
        if (t_done < 0) t_done = cyc;
      end
      if (t_done >= 0 && cyc == t_done + 1) busy_after = busy;
      if (t_done >= 0 && cyc > t_done + 3) break;
      bf_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      start = poke && (cyc == 5 || cyc == 9 || cyc == EXP_DONE8);
      if (stalled && (int'(idx_a) != pa || int'(idx_b) != pb ||
                      int'(twiddle_idx) != pt || int'(stage) != ps))
        nunstable++;
      if (bf_valid && bf_ready) begin
        if (ntx < 64) begin
          got_a[ntx] = int'(idx_a); got_b[ntx] = int'(idx_b);
          got_tw[ntx] = int'(twiddle_idx); got_st[ntx] = int'(stage);
        end
        ntx++;
      end
      stalled = bf_valid && !bf_ready;
      pa = int'(idx_a); pb = int'(idx_b); pt = int'(twiddle_idx); ps = int'(stage);
      @(negedge clk);
    end
    start = 1'b0;
    bf_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({busy, done, bf_valid, idx_a, idx_b, twiddle_idx, stage} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b valid=%b a=%0d b=%0d tw=%0d st=%0d want all 0",
               busy, done, bf_valid, idx_a, idx_b, twiddle_idx, stage);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, bf_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b done=%b valid=%b want 000", busy, done, bf_valid);
    end
  endtask

  task automatic test_basic;
    int ntx, t_done, ndone, nun;
    bit b0, ba;
    run8(0, 1'b0, ntx, t_done, ndone, nun, b0, ba);
    total++;
    if (b0 !== 1'b1) begin bad++; $display("FAIL basic_busy_rise: got %b want 1", b0); end
    total++;
    if (ntx != 12) begin bad++; $display("FAIL basic_count: got %0d want 12", ntx); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got_a[i] != exp_a[i] || got_b[i] != exp_b[i] || got_tw[i] != exp_tw[i] ||
          got_st[i] != i / 4) begin
        bad++;
        $display("FAIL basic_pair%0d: got (%0d,%0d) tw %0d st %0d want (%0d,%0d) tw %0d st %0d",
                 i, got_a[i], got_b[i], got_tw[i], got_st[i], exp_a[i], exp_b[i], exp_tw[i], i / 4);
      end
    end
    total++;
    if (t_done != EXP_DONE8) begin bad++; $display("FAIL basic_done_time: got %0d want %0d", t_done, EXP_DONE8); end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", ndone); end
  endtask

  task automatic test_stall;
    int ntx, t_done, ndone, nun;
    bit b0, ba;
    run8(1, 1'b0, ntx, t_done, ndone, nun, b0, ba);
    total++;
    if (ntx != 12) begin bad++; $display("FAIL stall_count: got %0d want 12", ntx); end
    total++;
    if (nun != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", nun); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got_a[i] != exp_a[i] || got_b[i] != exp_b[i] || got_tw[i] != exp_tw[i]) begin
        bad++;
        $display("FAIL stall_pair%0d: got (%0d,%0d) tw %0d want (%0d,%0d) tw %0d",
                 i, got_a[i], got_b[i], got_tw[i], exp_a[i], exp_b[i], exp_tw[i]);
      end
    end
    total++;
    if (ndone != 1) begin bad++; $display("FAIL stall_done_pulses: got %0d want 1", ndone); end
  endtask

  task automatic test_start_ignored;
    int ntx, t_done, ndone, nun;
    bit b0, ba;
    run8(0, 1'b1, ntx, t_done, ndone, nun, b0, ba);
    total++;
    if (ntx != 12) begin bad++; $display("FAIL restart_count: got %0d want 12", ntx); end
    total++;
    if (got_a[5] != 1 || got_b[5] != 3 || got_a[9] != 1 || got_b[9] != 5) begin
      bad++;
      $display("FAIL restart_pairs: got p5 (%0d,%0d) p9 (%0d,%0d) want (1,3) (1,5)",
               got_a[5], got_b[5], got_a[9], got_b[9]);
    end
    total++;
    if (t_done != EXP_DONE8) begin bad++; $display("FAIL restart_done_time: got %0d want %0d", t_done, EXP_DONE8); end
    total++;
    if (ba !== 1'b0) begin bad++; $display("FAIL start_at_done: got busy %b want 0", ba); end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    bit seen = 1'b0;
    bf_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, bf_valid, idx_a, idx_b, twiddle_idx, stage} !== 13'd0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b valid=%b a=%0d b=%0d tw=%0d st=%0d want all 0",
               busy, done, bf_valid, idx_a, idx_b, twiddle_idx, stage);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || bf_valid !== 1'b1 || idx_a !== 3'd0 || idx_b !== 3'd1 || stage !== 2'd0) begin
      bad++;
      $display("FAIL replay_first: got busy=%b valid=%b (%0d,%0d) st %0d want 1 1 (0,1) st 0",
               busy, bf_valid, idx_a, idx_b, stage);
    end
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL replay_done: got no done want done"); end
    bf_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_samples16;
    int ntx = 0, t_done = -1;
    ready16 = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int cyc = 0; cyc < 200 && t_done < 0; cyc++) begin
      if (done16) t_done = cyc;
      if (valid16 && ready16) begin
        if (ntx < 64) begin
          got_a[ntx] = int'(a16); got_b[ntx] = int'(b16);
          got_tw[ntx] = int'(tw16); got_st[ntx] = int'(st16);
        end
        ntx++;
      end
      if (t_done < 0) @(negedge clk);
    end
    ready16 = 1'b0;
    total++;
    if (ntx != 32) begin bad++; $display("FAIL n16_count: got %0d want 32", ntx); end
    total++;
    if (got_a[29] != 5 || got_b[29] != 13 || got_tw[29] != 5 || got_st[29] != 3) begin
      bad++;
      $display("FAIL n16_s3p5: got (%0d,%0d) tw %0d st %0d want (5,13) tw 5 st 3",
               got_a[29], got_b[29], got_tw[29], got_st[29]);
    end
    total++;
    if (got_a[13] != 9 || got_b[13] != 11 || got_tw[13] != 4) begin
      bad++;
      $display("FAIL n16_s1p5: got (%0d,%0d) tw %0d want (9,11) tw 4", got_a[13], got_b[13], got_tw[13]);
    end
    total++;
    if (t_done != EXP_DONE16) begin bad++; $display("FAIL n16_done_time: got %0d want %0d", t_done, EXP_DONE16); end
    repeat (2) @(negedge clk);
  endtask

`ifdef FFT_STAGE_BARRIER_EN
  task automatic test_barrier;
    int ntx = 0, fl = 0, t_done = -1, nidle = 0;
    bf_ready = 1'b1;
    bf_flushed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && t_done < 0; cyc++) begin
      if (done) t_done = cyc;
      if (busy && !bf_valid) begin
        nidle++;
        fl++;
        bf_flushed = (fl > 3);
      end else begin
        fl = 0;
        bf_flushed = 1'b0;
      end
      if (bf_valid && bf_ready) begin
        if (ntx < 64) begin got_a[ntx] = int'(idx_a); got_b[ntx] = int'(idx_b); end
        ntx++;
      end
      if (t_done < 0) @(negedge clk);
    end
    bf_flushed = 1'b1;
    bf_ready = 1'b0;
    total++;
    if (ntx != 12) begin bad++; $display("FAIL barrier_count: got %0d want 12", ntx); end
    total++;
    if (nidle != 12) begin bad++; $display("FAIL barrier_gap: got %0d idle cycles want 12", nidle); end
    total++;
    if (got_a[4] != 0 || got_b[4] != 2 || got_a[8] != 0 || got_b[8] != 4) begin
      bad++;
      $display("FAIL barrier_resume: got (%0d,%0d) (%0d,%0d) want (0,2) (0,4)",
               got_a[4], got_b[4], got_a[8], got_b[8]);
    end
    total++;
    if (t_done != 24) begin bad++; $display("FAIL barrier_done_time: got %0d want 24", t_done); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_samples16();
`ifdef FFT_STAGE_BARRIER_EN
    test_barrier();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
